launch_ctrl: RTL and testbench

Host-facing kernel launch controller that sits directly upstream of the block dispatcher. The host writes a thread count and issues launch commands through a small register interface. Accepted launches go into a queue. The controller then runs them one at a time:
- hold the dispatcher in reset between kernels,
- present the thread count and hold start until the dispatcher reports done,
- count completions and raise an interrupt.

---
 rtl/gpu_pkg.sv | 43 ++++
 rtl/launch_fifo.sv | 54 +++++
 rtl/launch_ctrl.sv | 131 +++++++++++++
 tb/tb_launch_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared register map, CONTROL/STATUS bit positions and launch FSM encoding.
// Pure declarations: no latency, no flow control.
package gpu_pkg;

  localparam logic [1:0] REG_THREAD_COUNT = 2'd0;
  localparam logic [1:0] REG_CONTROL      = 2'd1;
  localparam logic [1:0] REG_STATUS       = 2'd2;
  localparam logic [1:0] REG_DONE_COUNT   = 2'd3;

  localparam int CTRL_LAUNCH    = 0;
  localparam int CTRL_IRQ_CLEAR = 1;
  localparam int CTRL_ERR_CLEAR = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_IRQ  = 1;
  localparam int STAT_FULL = 2;
  localparam int STAT_ERR  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } launch_state_t;

  typedef struct packed {
    logic err_clear;
    logic irq_clear;
    logic launch;
  } ctrl_cmd_t;

  // A CONTROL write decoded into its command strobes; all zero for any other access.
  function automatic ctrl_cmd_t decode_ctrl(logic wr_en, logic [1:0] addr, logic [7:0] data);
    ctrl_cmd_t cmd;
    cmd = '0;
    if (wr_en && (addr == REG_CONTROL)) begin
      cmd.launch    = data[CTRL_LAUNCH];
      cmd.irq_clear = data[CTRL_IRQ_CLEAR];
      cmd.err_clear = data[CTRL_ERR_CLEAR];
    end
    return cmd;
  endfunction

endpackage

// File: rtl/launch_fifo.sv
// Launch queue: DEPTH x WIDTH synchronous FIFO, head visible combinationally, one-cycle update.
// Push while full and pop while empty are ignored; full ignores a same-cycle pop.
module launch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage carries no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/launch_ctrl.sv
// Host launch controller: queues launches, runs them one at a time on the dispatcher, counts completions.
// Launch to dispatch_start is two cycles when idle; a launch into a full queue or with zero threads is dropped and flags ERR.
module launch_ctrl
  import gpu_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_wr_en,
  input  logic [1:0] host_wr_addr,
  input  logic [7:0] host_wr_data,
  input  logic [1:0] host_rd_addr,
  output logic [7:0] host_rd_data,
  input  logic       dispatch_done,
  output logic       dispatch_start,
  output logic       dispatch_reset,
  output logic [7:0] dispatch_thread_count,
  output logic       busy,
  output logic       irq
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  launch_state_t    state_q;
  launch_state_t    state_d;
  ctrl_cmd_t        cmd;
  logic [7:0]       thread_count_q;
  logic [7:0]       done_count_q;
  logic             err_q;
  logic [7:0]       q_head;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] q_count_d;
  logic             wr_thread_count;
  logic             launch_ok;
  logic             launch_err;
  logic             q_pop;
  logic             kernel_done;
  logic             busy_d;

  assign cmd             = decode_ctrl(host_wr_en, host_wr_addr, host_wr_data);
  assign wr_thread_count = host_wr_en && (host_wr_addr == REG_THREAD_COUNT);

  // A zero-thread kernel would never report done, so it is refused at the door.
  assign launch_ok   = cmd.launch && !q_full && (thread_count_q != 8'd0);
  assign launch_err  = cmd.launch && !launch_ok;
  assign q_pop       = (state_q == ST_LOAD);
  assign kernel_done = (state_q == ST_RUN) && dispatch_done;

  launch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (8)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (launch_ok),
    .push_data (thread_count_q),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!q_empty) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (dispatch_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // busy and the dispatcher controls are registered from next-state so they line up with state_q.
  always_comb begin
    q_count_d = q_count + CNT_W'(launch_ok) - CNT_W'(q_pop);
    busy_d    = (state_d != ST_IDLE) || (q_count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q               <= ST_IDLE;
      dispatch_reset        <= 1'b1;
      dispatch_start        <= 1'b0;
      dispatch_thread_count <= 8'd0;
      busy                  <= 1'b0;
    end else begin
      state_q        <= state_d;
      dispatch_reset <= (state_d != ST_RUN);
      dispatch_start <= (state_d == ST_RUN);
      busy           <= busy_d;
      if (q_pop) dispatch_thread_count <= q_head;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thread_count_q <= 8'd0;
      done_count_q   <= 8'd0;
      irq            <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      if (wr_thread_count) thread_count_q <= host_wr_data;
      if (kernel_done) done_count_q <= done_count_q + 8'd1;
      // Set beats clear on both sticky flags.
      if (kernel_done)        irq <= 1'b1;
      else if (cmd.irq_clear) irq <= 1'b0;
      if (launch_err)         err_q <= 1'b1;
      else if (cmd.err_clear) err_q <= 1'b0;
    end
  end

  always_comb begin
    host_rd_data = 8'h00;
    case (host_rd_addr)
      REG_THREAD_COUNT: host_rd_data = thread_count_q;
      REG_STATUS: begin
        host_rd_data[STAT_BUSY] = busy;
        host_rd_data[STAT_IRQ]  = irq;
        host_rd_data[STAT_FULL] = q_full;
        host_rd_data[STAT_ERR]  = err_q;
      end
      REG_DONE_COUNT:   host_rd_data = done_count_q;
      default:          host_rd_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_launch_ctrl.sv
// Randomized scoreboard bench for launch_ctrl: a timestamp model predicts when each accepted kernel starts and ends.
// A negedge monitor pops expected kernels as dispatch_start rises; register reads are checked against the same model.
module tb_launch_ctrl;
  import gpu_pkg::*;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       host_wr_en = 1'b0;
  logic [1:0] host_wr_addr = 2'd0;
  logic [7:0] host_wr_data = 8'd0;
  logic [1:0] host_rd_addr = 2'd0;
  logic [7:0] host_rd_data;
  logic       dispatch_done = 1'b0;
  logic       dispatch_start;
  logic       dispatch_reset;
  logic [7:0] dispatch_thread_count;
  logic       busy;
  logic       irq;

  always #5 clk = ~clk;

  launch_ctrl #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .host_wr_en            (host_wr_en),
    .host_wr_addr          (host_wr_addr),
    .host_wr_data          (host_wr_data),
    .host_rd_addr          (host_rd_addr),
    .host_rd_data          (host_rd_data),
    .dispatch_done         (dispatch_done),
    .dispatch_start        (dispatch_start),
    .dispatch_reset        (dispatch_reset),
    .dispatch_thread_count (dispatch_thread_count),
    .busy                  (busy),
    .irq                   (irq)
  );

  // A kernel is described by the edges at which it was accepted, started running and finished.
  typedef struct {
    int tc;
    int acc;
    int st;
    int en;
  } kern_t;

  kern_t klist[$];
  kern_t exp_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  int    tc_model = 0;
  int    last_irq_clr = -1;
  int    last_err_set = -2;
  int    last_err_clr = -1;
  int    next_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Queue occupancy after edge c: accepted by then but not yet started.
  function automatic int q_after(int c);
    int n = 0;
    foreach (klist[i]) if (klist[i].acc <= c && klist[i].st > c) n++;
    return n;
  endfunction

  function automatic bit active_after(int c);
    foreach (klist[i]) if (klist[i].st - 1 <= c && c < klist[i].en) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ends_by(int c);
    int n = 0;
    foreach (klist[i]) if (klist[i].en <= c) n++;
    return n;
  endfunction

  function automatic int last_end_by(int c);
    int m = -2;
    foreach (klist[i]) if (klist[i].en <= c && klist[i].en > m) m = klist[i].en;
    return m;
  endfunction

  function automatic logic [7:0] exp_reg(logic [1:0] a);
    bit b, i, f, e;
    b = active_after(cyc) || (q_after(cyc) != 0);
    i = (last_end_by(cyc) >= 0) && (last_end_by(cyc) >= last_irq_clr);
    f = (q_after(cyc) == DEPTH);
    e = (last_err_set >= 0) && (last_err_set >= last_err_clr);
    case (a)
      REG_THREAD_COUNT: return 8'(tc_model);
      REG_CONTROL:      return 8'h00;
      REG_STATUS:       return {4'b0000, e, f, i, b};
      default:          return 8'(ends_by(cyc) % 256);
    endcase
  endfunction

  // Advance one edge, then schedule dispatch_done for the next edge from the model.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    host_wr_en    = 1'b0;
    dispatch_done = 1'b0;
    foreach (klist[i]) if (klist[i].en == cyc + 1) dispatch_done = 1'b1;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    int e = cyc + 1;
    if (a == REG_THREAD_COUNT) tc_model = int'(d);
    else if (a == REG_CONTROL) begin
      if (d[CTRL_LAUNCH]) begin
        if (tc_model != 0 && q_after(e - 1) < DEPTH) begin
          kern_t k;
          k.tc  = tc_model;
          k.acc = e;
          k.st  = e + 2;
          if (klist.size() > 0 && klist[$].en + 2 > k.st) k.st = klist[$].en + 2;
          k.en  = k.st + ((next_len > 0) ? next_len : int'($urandom_range(1, 6)));
          klist.push_back(k);
          exp_q.push_back(k);
        end else begin
          last_err_set = e;
        end
      end
      if (d[CTRL_IRQ_CLEAR]) last_irq_clr = e;
      if (d[CTRL_ERR_CLEAR]) last_err_clr = e;
    end
    host_wr_en   = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    tick();
  endtask

  task automatic check_reg(input logic [1:0] a, input string nm);
    host_rd_addr = a;
    #1;
    check(nm, 32'(host_rd_data), 32'(exp_reg(a)));
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 4; a++) check_reg(2'(a), $sformatf("%s_reg%0d", tag, a));
  endtask

  task automatic drain();
    int budget = 4000;
    while (budget > 0 && klist.size() > 0 && cyc < klist[$].en + 2) begin
      tick();
      budget--;
    end
    if (budget == 0) check("drain_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_edge(input int target);
    int budget = 4000;
    while (budget > 0 && cyc < target) begin
      tick();
      budget--;
    end
    if (budget == 0) check("wait_timeout", 32'(0), 32'(1));
  endtask

  task automatic model_reset();
    klist.delete();
    exp_q.delete();
    tc_model     = 0;
    last_irq_clr = -1;
    last_err_set = -2;
    last_err_clr = -1;
  endtask

  initial begin : monitor
    bit    prev = 1'b0;
    bit    have = 1'b0;
    int    rst_run = 0;
    kern_t cur;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_outputs", 32'({dispatch_reset, dispatch_start}), 32'(2'b10));
        prev    = 1'b0;
        have    = 1'b0;
        rst_run = 0;
      end else begin
        check("start_reset_complement", 32'(dispatch_reset), 32'(!dispatch_start));
        if (dispatch_start && !prev) begin
          check("unexpected_start", 32'(exp_q.size() != 0), 32'(1));
          if (exp_q.size() != 0) begin
            cur  = exp_q.pop_front();
            have = 1'b1;
            check("start_edge", 32'(cyc), 32'(cur.st));
            check("start_thread_count", 32'(dispatch_thread_count), 32'(cur.tc));
            check("reset_gap", 32'(rst_run >= 2), 32'(1));
          end
        end else if (dispatch_start && have) begin
          check("thread_count_held", 32'(dispatch_thread_count), 32'(cur.tc));
        end else if (!dispatch_start && prev && have) begin
          check("end_edge", 32'(cyc), 32'(cur.en));
          have = 1'b0;
        end
        rst_run = dispatch_reset ? rst_run + 1 : 0;
        prev    = dispatch_start;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int guard;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_all("reset");
    check("reset_dispatch_reset", 32'(dispatch_reset), 32'(1));
    check("reset_dispatch_start", 32'(dispatch_start), 32'(0));
    check("reset_thread_count", 32'(dispatch_thread_count), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_irq", 32'(irq), 32'(0));

    // Single kernel: 10 threads, done five cycles into RUN.
    next_len = 5;
    host_wr(REG_THREAD_COUNT, 8'd10);
    host_wr(REG_CONTROL, 8'h01);
    tick();
    check("e1_dispatch_reset", 32'(dispatch_reset), 32'(1));
    check("e1_dispatch_start", 32'(dispatch_start), 32'(0));
    tick();
    check("e2_thread_count", 32'(dispatch_thread_count), 32'(10));
    check("e2_dispatch_start", 32'(dispatch_start), 32'(1));
    check("e2_dispatch_reset", 32'(dispatch_reset), 32'(0));
    drain();
    check("first_irq", 32'(irq), 32'(1));
    check_all("first_done");
    host_wr(REG_CONTROL, 8'h02);
    check_all("irq_cleared");

    // Overfill: one long kernel running, then three launches into a two-deep queue.
    next_len = 12;
    host_wr(REG_THREAD_COUNT, 8'd10);
    host_wr(REG_CONTROL, 8'h01);
    tick();
    tick();
    next_len = 3;
    host_wr(REG_THREAD_COUNT, 8'd8);
    host_wr(REG_CONTROL, 8'h01);
    host_wr(REG_THREAD_COUNT, 8'd4);
    host_wr(REG_CONTROL, 8'h01);
    host_wr(REG_THREAD_COUNT, 8'd12);
    host_wr(REG_CONTROL, 8'h01);
    check_all("overfill");
    drain();
    check_all("overfill_done");

    // Zero-thread launch is refused.
    host_wr(REG_CONTROL, 8'h06);
    host_wr(REG_THREAD_COUNT, 8'd0);
    host_wr(REG_CONTROL, 8'h01);
    check_all("zero_tc");
    repeat (4) tick();
    check("zero_tc_busy", 32'(busy), 32'(0));

    // A stray done while idle must not count.
    dispatch_done = 1'b1;
    tick();
    repeat (2) tick();
    check_all("stray_done");

    // Random mix of register traffic.
    next_len = 0;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: host_wr(REG_THREAD_COUNT,
                         ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
        3, 4, 5: host_wr(REG_CONTROL, 8'h01);
        6:       host_wr(REG_CONTROL, 8'($urandom_range(0, 7)));
        7:       host_wr(2'($urandom_range(2, 3)), 8'($urandom_range(0, 255)));
        default: begin
          check_reg(2'($urandom_range(0, 3)), "random_read");
          tick();
        end
      endcase
    end
    drain();
    check_all("random_end");

    // Reset in the middle of a run with one kernel still queued.
    next_len = 30;
    host_wr(REG_THREAD_COUNT, 8'd55);
    host_wr(REG_CONTROL, 8'h01);
    host_wr(REG_THREAD_COUNT, 8'd66);
    host_wr(REG_CONTROL, 8'h01);
    wait_edge(klist[0].st + 3);
    reset = 1'b1;
    #1;
    check("async_reset_dispatch_reset", 32'(dispatch_reset), 32'(1));
    check("async_reset_dispatch_start", 32'(dispatch_start), 32'(0));
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check_all("after_reset");
    check("after_reset_thread_count", 32'(dispatch_thread_count), 32'(0));

    // Completion and IRQ_CLEAR land on the same edge: the set wins.
    next_len = 3;
    host_wr(REG_THREAD_COUNT, 8'd7);
    host_wr(REG_CONTROL, 8'h01);
    wait_edge(klist[$].en - 1);
    host_wr(REG_CONTROL, 8'h02);
    check("irq_set_wins", 32'(irq), 32'(1));
    check_all("irq_set_wins");
    host_wr(REG_CONTROL, 8'h02);

    // 256 kernels since reset: DONE_COUNT wraps to zero.
    next_len = 1;
    guard = 0;
    while (klist.size() < 256 && guard < 5000) begin
      host_wr(REG_THREAD_COUNT, 8'($urandom_range(1, 255)));
      if (q_after(cyc) < DEPTH) host_wr(REG_CONTROL, 8'h01);
      else tick();
      guard++;
      if (klist.size() == 200 && guard % 4 == 0) check_reg(REG_DONE_COUNT, "wrap_progress");
    end
    if (guard >= 5000) check("wrap_launch_timeout", 32'(0), 32'(1));
    drain();
    check_all("wrap_end");
    host_rd_addr = REG_DONE_COUNT;
    #1;
    check("done_count_wrap", 32'(host_rd_data), 32'(0));

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
